obi_lsu_manager: RTL and testbench

OBI manager-side load/store adapter that sits directly upstream of the byte-enabled OBI slave memory. It accepts one core load/store at a time, with byte, half-word or word size. It generates the OBI A-channel request with the correct byte-enable and lane-replicated write data, waits for the R-channel response, and returns lane-extracted, sign- or zero-extended read data to the core. Misaligned or illegal accesses are rejected locally, without an OBI transaction.

---
 rtl/obi_lsu_manager.sv | 98 +++++++++
 tb/tb_obi_lsu_manager.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/obi_lsu_manager.sv
// obi_lsu_manager: single-outstanding core load/store to OBI manager adapter with lane steering and extension
module obi_lsu_manager #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    lsu_valid_i,
  output logic                    lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_we_i,
  input  logic [1:0]              lsu_size_i,
  input  logic                    lsu_signed_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_rvalid_o,
  input  logic                    lsu_rready_i,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    lsu_err_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  output logic                    obi_rready_o,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t                    state_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic                      we_q;
  logic [1:0]                size_q;
  logic                      signed_q;
  logic [DATA_WIDTH/8-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_ext;
  logic                      err_q, mis;
  logic [7:0]                rb;
  logic [15:0]               rh;
  always_comb begin
    mis = lsu_size_i == 2'b11 || (lsu_size_i == 2'b01 && lsu_addr_i[0]) ||
          (lsu_size_i == 2'b10 && lsu_addr_i[1:0] != 2'b00);
    be_d = lsu_size_i == 2'b00 ? 4'b0001 << lsu_addr_i[1:0] :
           lsu_size_i == 2'b01 ? (lsu_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_d = lsu_size_i == 2'b00 ? {4{lsu_wdata_i[7:0]}} :
              lsu_size_i == 2'b01 ? {2{lsu_wdata_i[15:0]}} : lsu_wdata_i;
    rb = obi_rdata_i[8*addr_q[1:0] +: 8];
    rh = obi_rdata_i[16*addr_q[1] +: 16];
    rdata_ext = size_q == 2'b00 ? {{(DATA_WIDTH-8){signed_q & rb[7]}}, rb} :
                size_q == 2'b01 ? {{(DATA_WIDTH-16){signed_q & rh[15]}}, rh} : obi_rdata_i;
  end
  assign lsu_ready_o  = state_q == IDLE;
  assign obi_req_o    = state_q == REQ;
  assign obi_rready_o = state_q == WAIT;
  assign lsu_rvalid_o = state_q == RESP;
  assign obi_addr_o   = addr_q;
  assign obi_we_o     = we_q;
  assign obi_be_o     = be_q;
  assign obi_wdata_o  = wdata_q;
  assign lsu_rdata_o  = rdata_q;
  assign lsu_err_o    = err_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (lsu_valid_i) begin
          addr_q   <= lsu_addr_i;
          we_q     <= lsu_we_i;
          size_q   <= lsu_size_i;
          signed_q <= lsu_signed_i;
          be_q     <= be_d;
          wdata_q  <= wdata_d;
          rdata_q  <= '0;
          err_q    <= mis;
          state_q  <= mis ? RESP : REQ;
        end
        REQ: if (obi_gnt_i) state_q <= WAIT;
        WAIT: if (obi_rvalid_i) begin
          rdata_q <= (we_q || obi_err_i) ? '0 : rdata_ext;
          err_q   <= obi_err_i;
          state_q <= RESP;
        end
        RESP: if (lsu_rready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_obi_lsu_manager.sv
// tb_obi_lsu_manager: directed-vector self-checking bench for obi_lsu_manager
module tb_obi_lsu_manager;
  logic        clk_i = 0, reset_i = 0;
  logic        lsu_valid_i = 0, lsu_we_i = 0, lsu_signed_i = 0, lsu_rready_i = 0;
  logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0, obi_rdata_i = 0;
  logic [1:0]  lsu_size_i = 0;
  logic        obi_gnt_i = 0, obi_rvalid_i = 0, obi_err_i = 0;
  logic        lsu_ready_o, lsu_rvalid_o, lsu_err_o, obi_req_o, obi_we_o, obi_rready_o;
  logic [31:0] lsu_rdata_o, obi_addr_o, obi_wdata_o;
  logic [3:0]  obi_be_o;
  logic [31:0] mem [64];
  int checks = 0, failures = 0, n_txn = 0;

  obi_lsu_manager dut (
    .clk_i(clk_i), .reset_i(reset_i), .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_signed_i(lsu_signed_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rready_i(lsu_rready_i), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o), .obi_rdata_i(obi_rdata_i),
    .obi_err_i(obi_err_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (obi_req_o && obi_gnt_i) n_txn++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One core transaction; slave stalls gs cycles on grant, rs cycles on rvalid, core stalls cs cycles on rready
  task automatic xfer(input string tag, input logic [31:0] a, input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] wd, input int gs, input int rs, input int cs,
                      input logic oerr, input logic mis, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] erd, input logic eerr);
    int t0;
    t0 = n_txn;
    chk({tag, ".ready"}, {31'b0, lsu_ready_o}, 1);
    lsu_valid_i = 1; lsu_addr_i = a; lsu_we_i = we; lsu_size_i = sz; lsu_signed_i = sg; lsu_wdata_i = wd;
    step();
    lsu_valid_i = 0;
    if (mis) begin
      chk({tag, ".mis_rvalid"}, {31'b0, lsu_rvalid_o}, 1);
      chk({tag, ".mis_err"}, {31'b0, lsu_err_o}, 1);
      chk({tag, ".mis_rdata"}, lsu_rdata_o, 0);
      chk({tag, ".mis_req"}, {31'b0, obi_req_o}, 0);
    end else begin
      chk({tag, ".req"}, {31'b0, obi_req_o}, 1);
      chk({tag, ".addr"}, obi_addr_o, a);
      chk({tag, ".we"}, {31'b0, obi_we_o}, {31'b0, we});
      chk({tag, ".be"}, {28'b0, obi_be_o}, {28'b0, ebe});
      chk({tag, ".wdata"}, obi_wdata_o, ewd);
      for (int i = 0; i < gs; i++) begin
        step();
        chk({tag, ".hold_req"}, {31'b0, obi_req_o}, 1);
        chk({tag, ".hold_be"}, {28'b0, obi_be_o}, {28'b0, ebe});
        chk({tag, ".hold_wdata"}, obi_wdata_o, ewd);
        chk({tag, ".hold_addr"}, obi_addr_o, a);
      end
      obi_gnt_i = 1;
      obi_rvalid_i = 1;
      obi_rdata_i = 32'hBAD0BAD0;
      step();
      obi_gnt_i = 0;
      obi_rvalid_i = 0;
      if (we) for (int b = 0; b < 4; b++) if (ebe[b]) mem[a[7:2]][8*b +: 8] = ewd[8*b +: 8];
      chk({tag, ".rready"}, {31'b0, obi_rready_o}, 1);
      chk({tag, ".rv_early"}, {31'b0, lsu_rvalid_o}, 0);
      for (int i = 0; i < rs; i++) step();
      obi_rvalid_i = 1; obi_err_i = oerr; obi_rdata_i = mem[a[7:2]];
      step();
      obi_rvalid_i = 0; obi_err_i = 0; obi_rdata_i = 0;
      chk({tag, ".rvalid"}, {31'b0, lsu_rvalid_o}, 1);
      chk({tag, ".rdata"}, lsu_rdata_o, erd);
      chk({tag, ".err"}, {31'b0, lsu_err_o}, {31'b0, eerr});
    end
    for (int i = 0; i < cs; i++) begin
      step();
      chk({tag, ".held_rvalid"}, {31'b0, lsu_rvalid_o}, 1);
      chk({tag, ".held_rdata"}, lsu_rdata_o, erd);
      chk({tag, ".held_err"}, {31'b0, lsu_err_o}, {31'b0, eerr});
    end
    lsu_rready_i = 1;
    step();
    lsu_rready_i = 0;
    chk({tag, ".idle"}, {31'b0, lsu_ready_o}, 1);
    chk({tag, ".ntxn"}, n_txn - t0, mis ? 0 : 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 0;
    reset_i = 1;
    step();
    step();
    reset_i = 0;
    chk("rst.ready", {31'b0, lsu_ready_o}, 1);
    chk("rst.req", {31'b0, obi_req_o}, 0);
    chk("rst.rready", {31'b0, obi_rready_o}, 0);
    chk("rst.rvalid", {31'b0, lsu_rvalid_o}, 0);
    chk("rst.err", {31'b0, lsu_err_o}, 0);
    chk("rst.addr", obi_addr_o, 0);
    chk("rst.be", {28'b0, obi_be_o}, 0);
    chk("rst.wdata", obi_wdata_o, 0);
    chk("rst.we", {31'b0, obi_we_o}, 0);
    chk("rst.rdata", lsu_rdata_o, 0);
    //   tag       addr         we sz     sg wdata          gs rs cs oe mis be       ewd            erd            eerr
    xfer("sw",    32'h10, 1, 2'b10, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0,        0);
    xfer("lw",    32'h10, 0, 2'b10, 0, 32'h0,        0, 0, 0, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
    xfer("sb",    32'h13, 1, 2'b00, 0, 32'h00000080, 0, 0, 0, 0, 0, 4'b1000, 32'h80808080, 32'h0,        0);
    xfer("lbs",   32'h13, 0, 2'b00, 1, 32'h0,        0, 0, 0, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0);
    xfer("lbu",   32'h13, 0, 2'b00, 0, 32'h0,        0, 0, 0, 0, 0, 4'b1000, 32'h0,        32'h00000080, 0);
    xfer("lbs0",  32'h10, 0, 2'b00, 1, 32'h0,        0, 0, 0, 0, 0, 4'b0001, 32'h0,        32'hFFFFFFEF, 0);
    xfer("sh",    32'h22, 1, 2'b01, 0, 32'h00008001, 0, 0, 0, 0, 0, 4'b1100, 32'h80018001, 32'h0,        0);
    xfer("lhs",   32'h22, 0, 2'b01, 1, 32'h0,        0, 0, 0, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0);
    xfer("sw2",   32'h30, 1, 2'b10, 0, 32'h12345678, 0, 0, 0, 0, 0, 4'b1111, 32'h12345678, 32'h0,        0);
    xfer("lhu",   32'h32, 0, 2'b01, 0, 32'h0,        0, 0, 0, 0, 0, 4'b1100, 32'h0,        32'h00001234, 0);
    xfer("lbu1",  32'h31, 0, 2'b00, 1, 32'h0,        0, 0, 0, 0, 0, 4'b0010, 32'h0,        32'h00000056, 0);
    xfer("mis_h", 32'h01, 0, 2'b01, 0, 32'h0,        0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,        1);
    xfer("mis_w", 32'h02, 0, 2'b10, 0, 32'h0,        0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,        1);
    xfer("ill",   32'h00, 1, 2'b11, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,        1);
    xfer("stall", 32'h30, 0, 2'b10, 0, 32'h0,        4, 3, 2, 0, 0, 4'b1111, 32'h0,        32'h12345678, 0);
    xfer("oerr",  32'h30, 0, 2'b10, 0, 32'h0,        1, 1, 1, 1, 0, 4'b1111, 32'h0,        32'h0,        1);
    lsu_valid_i = 1; lsu_addr_i = 32'h10; lsu_we_i = 0; lsu_size_i = 2'b10; lsu_signed_i = 0;
    step();
    lsu_valid_i = 0;
    obi_gnt_i = 1;
    step();
    obi_gnt_i = 0;
    chk("rstw.in_wait", {31'b0, obi_rready_o}, 1);
    reset_i = 1;
    step();
    reset_i = 0;
    chk("rstw.ready", {31'b0, lsu_ready_o}, 1);
    chk("rstw.rready", {31'b0, obi_rready_o}, 0);
    chk("rstw.req", {31'b0, obi_req_o}, 0);
    obi_rvalid_i = 1; obi_rdata_i = 32'hCAFEF00D;
    step();
    obi_rvalid_i = 0; obi_rdata_i = 0;
    chk("rstw.stray_rvalid", {31'b0, lsu_rvalid_o}, 0);
    chk("rstw.still_idle", {31'b0, lsu_ready_o}, 1);
    step();
    chk("rstw.stray_late", {31'b0, lsu_rvalid_o}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
